// File: rtl/interp_outfifo.sv
// interp_outfifo
//   Rate-matching output buffer for the nearest-neighbor interpolator.
//   Samples are captured on the interpolator strobe and presented on a
//   valid/ready stream. When the buffer is full and not being read, the
//   incoming sample is dropped and counted.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_ce, i_data        sample strobe and sample from the interpolator
//   o_valid, i_ready    output handshake
//   o_data              oldest stored sample (meaningful while o_valid)
//   o_fill              stored sample count, including the presented one
//   o_overflow          sticky "a sample was dropped" flag
//   i_clr_overflow      clears o_overflow and o_drops
//   o_drops             saturating dropped-sample count
module interp_outfifo #(
    parameter int DW     = 28,
    parameter int LGFIFO = 4,
    parameter int DROPW  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ce,
    input  logic [DW-1:0]     i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DW-1:0]     o_data,
    output logic [LGFIFO:0]   o_fill,
    output logic              o_overflow,
    input  logic              i_clr_overflow,
    output logic [DROPW-1:0]  o_drops
);

    localparam int DEPTH = 1 << LGFIFO;
    localparam logic [LGFIFO:0] FULL_CNT = DEPTH[LGFIFO:0];

    logic [DW-1:0]     mem [DEPTH];
    logic [LGFIFO-1:0] wr, rd;
    logic              full, rd_en, wr_en, drop;

    assign full    = (o_fill == FULL_CNT);
    assign o_valid = (o_fill != '0);
    assign o_data  = mem[rd];

    // A read in the same cycle frees a slot, so a full buffer that is
    // being drained still accepts the new sample.
    assign rd_en = o_valid && i_ready;
    assign wr_en = i_ce && (!full || rd_en);
    assign drop  = i_ce && full && !rd_en;

    // Storage is not reset; pointers make stale contents unreachable.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_reset)
            mem[wr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr     <= '0;
            rd     <= '0;
            o_fill <= '0;
        end else begin
            if (wr_en)
                wr <= wr + 1'b1;
            if (rd_en)
                rd <= rd + 1'b1;
            if (wr_en && !rd_en)
                o_fill <= o_fill + 1'b1;
            else if (rd_en && !wr_en)
                o_fill <= o_fill - 1'b1;
        end
    end

    // A drop in the same cycle as a clear wins: the flag stays set and
    // the count restarts at one.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_overflow <= 1'b0;
            o_drops    <= '0;
        end else if (drop) begin
            o_overflow <= 1'b1;
            if (i_clr_overflow)
                o_drops <= DROPW'(1);
            else if (o_drops != '1)
                o_drops <= o_drops + 1'b1;
        end else if (i_clr_overflow) begin
            o_overflow <= 1'b0;
            o_drops    <= '0;
        end
    end

endmodule
